jtriders_busarb: RTL and testbench

- 68000-style bus arbiter: the responder end of the BRn/BGn/BGACKn handshake driven by the riders/tmnt2 protection DMA master.
- Samples BRn, waits for the CPU's current bus cycle to finish, asserts BGn, tracks ownership through BGACKn, then hands the bus back to the CPU.
- Also selects which master drives the shared RAM/object-RAM port and produces bus_busy back to the DMA master.

---
 rtl/jtriders_pkg.sv | 17 +
 rtl/jtriders_busarb_mux.sv | 65 ++++++
 rtl/jtriders_busarb.sv | 153 +++++++++++++++
 tb/tb_jtriders_busarb.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/jtriders_pkg.sv
// Shared types and defaults for the riders/tmnt2 bus arbiter.
// Arbitration states and 68000 timing constants.
package jtriders_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_CYC,
    DLY,
    GRANT,
    OWN,
    REL
  } arb_st_e;

  localparam int GNT_DLY_DEF = 2;
  localparam int TOUT_DEF    = 255;

endpackage

// File: rtl/jtriders_busarb_mux.sv
// Shared memory port master select and DMA busy tracking.
// The mux is purely combinational on dma_owner.
module jtriders_busarb_mux
  import jtriders_pkg::*;
#(
  parameter int AW = 23
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dma_owner,
  input  logic        cpu_asn,
  input  logic [AW:1] cpu_addr,
  input  logic [1:0]  cpu_dsn,
  input  logic        cpu_we,
  input  logic [AW:1] dma_addr,
  input  logic [1:0]  dma_dsn,
  input  logic        dma_we,
  input  logic        mem_ok,
  output logic [AW:1] mem_addr,
  output logic [1:0]  mem_dsn,
  output logic        mem_we,
  output logic        bus_busy
);

  logic       busy_q, busy_d;
  logic [1:0] dsn_q, dsn_d;

  always_comb begin
    mem_addr = cpu_addr;
    mem_dsn  = cpu_asn ? 2'b11 : cpu_dsn;
    mem_we   = cpu_we;
    if (dma_owner) begin
      mem_addr = dma_addr;
      mem_dsn  = dma_dsn;
      mem_we   = dma_we;
    end
  end

  // A new access is any active strobe pattern not seen on the previous clk.
  always_comb begin
    busy_d = 1'b0;
    dsn_d  = 2'b11;
    if (dma_owner) begin
      dsn_d  = dma_dsn;
      busy_d = busy_q;
      if (dma_dsn != 2'b11 && dma_dsn != dsn_q)
        busy_d = 1'b1;
      else if (mem_ok)
        busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= 1'b0;
      dsn_q  <= 2'b11;
    end else begin
      busy_q <= busy_d;
      dsn_q  <= dsn_d;
    end
  end

  assign bus_busy = busy_q & dma_owner;

endmodule

// File: rtl/jtriders_busarb.sv
// 68000 BR/BG/BGACK responder for the protection DMA master.
// Grants the bus only between CPU cycles and hands it back after release.
module jtriders_busarb
  import jtriders_pkg::*;
#(
  parameter int GNT_DLY = GNT_DLY_DEF,
  parameter int TOUT    = TOUT_DEF,
  parameter int AW      = 23
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cen_8,
  input  logic        cpu_asn,
  input  logic [AW:1] cpu_addr,
  input  logic [1:0]  cpu_dsn,
  input  logic        cpu_we,
  input  logic [AW:1] dma_addr,
  input  logic [1:0]  dma_dsn,
  input  logic        dma_we,
  input  logic        BRn,
  input  logic        BGACKn,
  input  logic        mem_ok,
  output logic        BGn,
  output logic        cpu_haltn,
  output logic        bus_busy,
  output logic [AW:1] mem_addr,
  output logic [1:0]  mem_dsn,
  output logic        mem_we,
  output logic        dma_owner
);

  localparam int CW = $clog2(GNT_DLY + 1);
  localparam int TW = $clog2(TOUT + 1);

  arb_st_e       state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] tout_q, tout_d;
  logic          bgn_q, bgn_d;
  logic          haltn_q, haltn_d;
  logic          own_q, own_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tout_d  = tout_q;
    bgn_d   = bgn_q;
    haltn_d = haltn_q;
    own_d   = own_q;
    unique case (state_q)
      IDLE: begin
        if (cen_8 && !BRn) state_d = WAIT_CYC;
      end
      WAIT_CYC: begin
        if (cen_8) begin
          if (BRn) begin
            state_d = IDLE;
          end else if (cpu_asn) begin
            cnt_d   = CW'(GNT_DLY);
            state_d = DLY;
          end
        end
      end
      DLY: begin
        if (cen_8) begin
          if (BRn) begin
            cnt_d   = '0;
            state_d = IDLE;
          end else if (cnt_q <= CW'(1)) begin
            cnt_d   = '0;
            bgn_d   = 1'b0;
            haltn_d = 1'b0;
            tout_d  = TW'(TOUT);
            state_d = GRANT;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
      end
      // The ack is sampled every clk so BGn drops out within one clk.
      GRANT: begin
        if (!BGACKn) begin
          bgn_d   = 1'b1;
          own_d   = 1'b1;
          tout_d  = '0;
          state_d = OWN;
        end else if (cen_8) begin
          if (BRn || tout_q <= TW'(1)) begin
            bgn_d   = 1'b1;
            haltn_d = 1'b1;
            tout_d  = '0;
            state_d = IDLE;
          end else begin
            tout_d = tout_q - TW'(1);
          end
        end
      end
      OWN: begin
        if (cen_8 && BGACKn) begin
          own_d   = 1'b0;
          state_d = REL;
        end
      end
      REL: begin
        if (cen_8) begin
          haltn_d = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      tout_q  <= '0;
      bgn_q   <= 1'b1;
      haltn_q <= 1'b1;
      own_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tout_q  <= tout_d;
      bgn_q   <= bgn_d;
      haltn_q <= haltn_d;
      own_q   <= own_d;
    end
  end

  assign BGn       = bgn_q;
  assign cpu_haltn = haltn_q;
  assign dma_owner = own_q;

  jtriders_busarb_mux #(.AW(AW)) u_mux (
    .clk       (clk),
    .rst       (rst),
    .dma_owner (own_q),
    .cpu_asn   (cpu_asn),
    .cpu_addr  (cpu_addr),
    .cpu_dsn   (cpu_dsn),
    .cpu_we    (cpu_we),
    .dma_addr  (dma_addr),
    .dma_dsn   (dma_dsn),
    .dma_we    (dma_we),
    .mem_ok    (mem_ok),
    .mem_addr  (mem_addr),
    .mem_dsn   (mem_dsn),
    .mem_we    (mem_we),
    .bus_busy  (bus_busy)
  );

endmodule

// File: tb/tb_jtriders_busarb.sv
// Bench for jtriders_busarb: tick-level reference model plus
// directed scenarios with literal timing expectations.
module tb_jtriders_busarb;

  localparam int GD = 2;
  localparam int TO = 255;

  logic        clk = 1'b0;
  logic        rst, cen_8, cpu_asn, cpu_we, dma_we;
  logic        BRn, BGACKn, mem_ok;
  logic [23:1] cpu_addr, dma_addr;
  logic [1:0]  cpu_dsn, dma_dsn;
  logic        BGn, cpu_haltn, bus_busy, mem_we, dma_owner;
  logic [23:1] mem_addr;
  logic [1:0]  mem_dsn;

  int total = 0;
  int bad   = 0;
  bit chk_en = 0;

  jtriders_busarb #(.GNT_DLY(GD), .TOUT(TO), .AW(23)) dut (
    .clk(clk), .rst(rst), .cen_8(cen_8),
    .cpu_asn(cpu_asn), .cpu_addr(cpu_addr),
    .cpu_dsn(cpu_dsn), .cpu_we(cpu_we),
    .dma_addr(dma_addr), .dma_dsn(dma_dsn),
    .dma_we(dma_we), .BRn(BRn), .BGACKn(BGACKn),
    .mem_ok(mem_ok), .BGn(BGn),
    .cpu_haltn(cpu_haltn), .bus_busy(bus_busy),
    .mem_addr(mem_addr), .mem_dsn(mem_dsn),
    .mem_we(mem_we), .dma_owner(dma_owner)
  );

  always #5 clk = ~clk;

  initial begin
    cen_8 = 1'b0;
    forever begin
      repeat (3) @(posedge clk);
      #1 cen_8 = 1'b1;
      @(posedge clk);
      #1 cen_8 = 1'b0;
    end
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  // Reference model: request/grant/ownership flags and tick counts.
  bit       m_req, m_granted, m_owned, m_rel, m_busy;
  int       m_dly, m_tout;
  bit [1:0] m_last;

  always @(posedge clk) begin
    if (rst) begin
      m_req = 0; m_granted = 0; m_owned = 0;
      m_rel = 0; m_busy = 0; m_dly = 0;
      m_tout = 0; m_last = 2'b11;
    end else begin
      if (!m_owned) begin
        m_busy = 0;
        m_last = 2'b11;
      end else begin
        if (dma_dsn != 2'b11 && dma_dsn != m_last)
          m_busy = 1;
        else if (mem_ok)
          m_busy = 0;
        m_last = dma_dsn;
      end
      if (m_granted && !BGACKn) begin
        m_granted = 0;
        m_owned   = 1;
      end else if (cen_8) begin
        if (m_owned) begin
          if (BGACKn) begin
            m_owned = 0;
            m_rel   = 1;
          end
        end else if (m_rel) begin
          m_rel = 0;
        end else if (m_granted) begin
          m_tout++;
          if (BRn || m_tout == TO) m_granted = 0;
        end else if (m_dly > 0) begin
          if (BRn) m_dly = 0;
          else begin
            m_dly--;
            if (m_dly == 0) begin
              m_granted = 1;
              m_tout    = 0;
            end
          end
        end else if (m_req) begin
          if (BRn) m_req = 0;
          else if (cpu_asn) begin
            m_req = 0;
            m_dly = GD;
          end
        end else if (!BRn) begin
          m_req = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("BGn", 32'(BGn), 32'(!m_granted));
      chk("haltn", 32'(cpu_haltn),
          32'(!(m_granted || m_owned || m_rel)));
      chk("owner", 32'(dma_owner), 32'(m_owned));
      chk("busy", 32'(bus_busy), 32'(m_busy && m_owned));
      chk("mem_addr", 32'(mem_addr),
          32'(m_owned ? dma_addr : cpu_addr));
      chk("mem_dsn", 32'(mem_dsn),
          32'(m_owned ? dma_dsn :
              (cpu_asn ? 2'b11 : cpu_dsn)));
      chk("mem_we", 32'(mem_we),
          32'(m_owned ? dma_we : cpu_we));
    end
  end

  task automatic wait_clk();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_tick();
    @(posedge clk);
    while (!cen_8) @(posedge clk);
    #2;
  endtask

  task automatic get_grant(output int n);
    n = 0;
    BRn = 1'b0;
    cpu_asn = 1'b1;
    do begin
      wait_tick();
      n++;
    end while (BGn !== 1'b0 && n < 40);
  endtask

  int n;

  initial begin
    rst = 1'b1; cpu_asn = 1'b1; cpu_we = 1'b0;
    cpu_dsn = 2'b00; cpu_addr = 23'h012345;
    dma_addr = 23'h000000; dma_dsn = 2'b11;
    dma_we = 1'b0; BRn = 1'b1; BGACKn = 1'b1;
    mem_ok = 1'b0;
    wait_clk();
    chk_en = 1;
    wait_clk();
    rst = 1'b0;
    chk("rst_BGn", 32'(BGn), 1);
    chk("rst_haltn", 32'(cpu_haltn), 1);
    chk("rst_owner", 32'(dma_owner), 0);
    chk("rst_busy", 32'(bus_busy), 0);

    // Request seen, CPU idle seen, then GD ticks of delay.
    get_grant(n);
    chk("grant_ticks", 32'(n), 32'(2 + GD));
    chk("grant_haltn", 32'(cpu_haltn), 0);
    wait_clk();
    BGACKn = 1'b0;
    wait_clk();
    chk("ack_BGn", 32'(BGn), 1);
    chk("ack_owner", 32'(dma_owner), 1);
    dma_addr = 23'h180d05; dma_dsn = 2'b00; dma_we = 1'b1;
    wait_clk();
    chk("own_addr", 32'(mem_addr), 32'h180d05);
    chk("own_busy", 32'(bus_busy), 1);
    mem_ok = 1'b1;
    wait_clk();
    mem_ok = 1'b0;
    chk("ok_busy", 32'(bus_busy), 0);
    dma_dsn = 2'b01;
    wait_clk();
    chk("dsn_chg_busy", 32'(bus_busy), 1);
    dma_dsn = 2'b11; dma_we = 1'b0;
    BRn = 1'b1; BGACKn = 1'b1;
    wait_tick();
    chk("rel_owner", 32'(dma_owner), 0);
    chk("rel_haltn", 32'(cpu_haltn), 0);
    chk("rel_mem_addr", 32'(mem_addr), 32'h012345);
    wait_tick();
    chk("rel_haltn_up", 32'(cpu_haltn), 1);

    // CPU cycle in flight holds off the grant.
    cpu_asn = 1'b0;
    BRn = 1'b0;
    repeat (5) wait_tick();
    chk("cyc_BGn", 32'(BGn), 1);
    cpu_asn = 1'b1;
    wait_tick();
    n = 0;
    while (BGn !== 1'b0 && n < 40) begin
      wait_tick();
      n++;
    end
    chk("cyc_dly_ticks", 32'(n), 32'(GD));
    BRn = 1'b1;
    wait_tick();
    chk("drop_BGn", 32'(BGn), 1);
    chk("drop_haltn", 32'(cpu_haltn), 1);

    // Request withdrawn during the delay count.
    BRn = 1'b0;
    repeat (3) wait_tick();
    BRn = 1'b1;
    wait_tick();
    chk("wd_BGn", 32'(BGn), 1);
    repeat (3) wait_tick();
    chk("wd_BGn_late", 32'(BGn), 1);
    get_grant(n);
    chk("wd_regrant", 32'(n), 32'(2 + GD));
    BRn = 1'b1;
    wait_tick();

    // No acknowledge: grant withdrawn on tick TO.
    get_grant(n);
    n = 0;
    while (BGn === 1'b0 && n < 300) begin
      wait_tick();
      n++;
    end
    BRn = 1'b1;
    chk("tout_ticks", 32'(n), 32'(TO));
    chk("tout_haltn", 32'(cpu_haltn), 1);
    wait_tick();

    // Reset while the DMA master owns the bus.
    get_grant(n);
    BGACKn = 1'b0;
    wait_clk();
    chk("pre_rst_owner", 32'(dma_owner), 1);
    rst = 1'b1; BRn = 1'b1; BGACKn = 1'b1;
    wait_clk();
    chk("mrst_owner", 32'(dma_owner), 0);
    chk("mrst_BGn", 32'(BGn), 1);
    chk("mrst_haltn", 32'(cpu_haltn), 1);
    chk("mrst_addr", 32'(mem_addr), 32'h012345);
    rst = 1'b0;
    repeat (3) wait_tick();

    chk_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

endmodule
